// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS control path. The datapath and
// the ALU control import these as well.
// Contents: state encoding, opcode values, alu_op / alu_src_b / pc_source
// encodings, the control-word struct and an opcode legality helper.
// Optional feature macro: MC_CTRL_ADDI_EN (adds addi support).
package mc_ctrl_pkg;

  // State encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_word_t;

  // True when DECODE has somewhere to dispatch this opcode.
  function automatic logic op_is_legal(input logic [5:0] op_v);
    logic legal;
    case (op_v)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: legal = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      OP_ADDI:                              legal = 1'b1;
`endif
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
// Purely combinational state-to-control-word decode (Moore outputs, except
// that FETCH qualifies ir_write/pc_write with mem_ready and DECODE flags an
// unrecognised opcode).
// Ports:
//   state_i      current FSM state
//   op_i         instruction opcode (only looked at in DECODE)
//   mem_ready_i  memory handshake (only looked at in FETCH)
//   ctrl_o       control word for the datapath
// Optional feature macro: MC_CTRL_ADDI_EN (decodes ADDI_EX / ADDI_WB).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_word_t ctrl_o
);

  // Control word decode; unlisted fields stay 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ALUB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // Only latch IR and bump the PC when the read actually returns.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl_o.alu_src_b  = ALUB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~op_is_legal(op_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_REG;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = ALUB_REG;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM of the multicycle MIPS datapath. Holds the state register
// and next-state logic; the control word comes from mc_ctrl_decode.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   op, mem_ready   opcode (IR[31:26]) and memory completion handshake
//   pc_write ... illegal_op   datapath enables and selects (all 0 in reset)
//   state           current state, for debug
// Optional feature macro: MC_CTRL_ADDI_EN (adds the addi path).
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_word_t ctrl_s;
  ctrl_word_t ctrl_gated_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; op is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        // op can only legitimately be lw or sw here; anything else aborts.
        if (op == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (op == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_s)
  );

  // While reset is low the datapath sees no enable and all-zero selects, so
  // an interrupted instruction cannot write anything in the reset cycle.
  always_comb begin
    if (rst_n) begin
      ctrl_gated_s = ctrl_s;
    end else begin
      ctrl_gated_s = '0;
    end
  end

  assign pc_write      = ctrl_gated_s.pc_write;
  assign pc_write_cond = ctrl_gated_s.pc_write_cond;
  assign i_or_d        = ctrl_gated_s.i_or_d;
  assign mem_read      = ctrl_gated_s.mem_read;
  assign mem_write     = ctrl_gated_s.mem_write;
  assign ir_write      = ctrl_gated_s.ir_write;
  assign mem_to_reg    = ctrl_gated_s.mem_to_reg;
  assign reg_dst       = ctrl_gated_s.reg_dst;
  assign reg_write     = ctrl_gated_s.reg_write;
  assign alu_src_a     = ctrl_gated_s.alu_src_a;
  assign alu_src_b     = ctrl_gated_s.alu_src_b;
  assign alu_op        = ctrl_gated_s.alu_op;
  assign pc_source     = ctrl_gated_s.pc_source;
  assign illegal_op    = ctrl_gated_s.illegal_op;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Self-checking bench for multicycle_control. For each instruction it builds
// the expected per-cycle path (state number plus mem_ready value) from the
// instruction class and wait counts, then compares state and every control
// output each cycle against a table of per-state outputs.
// Honours MC_CTRL_ADDI_EN the same way the design does.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  int exp_st_q[$];
  bit exp_mr_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  function automatic bit legal_op(logic [5:0] o);
    bit l;
    l = (o == 6'h23) || (o == 6'h2b) || (o == 6'h00) || (o == 6'h04) || (o == 6'h02);
`ifdef MC_CTRL_ADDI_EN
    l = l || (o == 6'h08);
`endif
    return l;
  endfunction

  // Required outputs per state, straight from the state/output table.
  function automatic logic [16:0] exp_out(int st, bit mr, logic [5:0] o);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mw = 0, irw = 0, m2r = 0;
    logic rd = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 2'd0, aop = 2'd0, pcs = 2'd0;
    case (st)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1: begin asb = 2'b11; ill = !legal_op(o); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iod = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      9: begin pw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [16:0] dut_out();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal_op};
  endfunction

  task automatic push_mem(int st, int waits);
    for (int w = 0; w < waits; w++) begin exp_st_q.push_back(st); exp_mr_q.push_back(1'b0); end
    exp_st_q.push_back(st); exp_mr_q.push_back(1'b1);
  endtask

  // Non-memory stage: mem_ready is random to show it is ignored.
  task automatic push_plain(int st);
    exp_st_q.push_back(st); exp_mr_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic build_path(logic [5:0] o, int wf, int wm);
    exp_st_q.delete(); exp_mr_q.delete();
    push_mem(0, wf);
    push_plain(1);
    if (legal_op(o)) begin
      case (o)
        6'h23: begin push_plain(2); push_mem(3, wm); push_plain(4); end
        6'h2b: begin push_plain(2); push_mem(5, wm); end
        6'h00: begin push_plain(6); push_plain(7); end
        6'h04: push_plain(8);
        6'h02: push_plain(9);
        6'h08: begin push_plain(10); push_plain(11); end
        default: ;
      endcase
    end
  endtask

  // Run the first n path entries; op is random outside DECODE/MEM_ADDR.
  task automatic run_path(string name, logic [5:0] o, int n);
    int st;
    bit mr;
    for (int i = 0; i < n; i++) begin
      st = exp_st_q[i];
      mr = exp_mr_q[i];
      op = (st == 1 || st == 2) ? o : 6'($urandom);
      mem_ready = mr;
      @(negedge clk);
      checks++;
      if (state !== 4'(st)) begin
        errors++;
        $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, state, st);
      end
      checks++;
      if (dut_out() !== exp_out(st, mr, o)) begin
        errors++;
        $display("FAIL %s outputs cyc%0d st%0d: got %h want %h", name, i, st, dut_out(), exp_out(st, mr, o));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(string name, logic [5:0] o, int wf, int wm);
    build_path(o, wf, wm);
    run_path(name, o, exp_st_q.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'h23;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if (dut_out() !== 17'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0", dut_out()); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();      run_instr("lw", 6'h23, 0, 0);      endtask
  task automatic test_rtype();   run_instr("rtype", 6'h00, 0, 0);   endtask
  task automatic test_beq();     run_instr("beq", 6'h04, 0, 0);     endtask
  task automatic test_jump();    run_instr("j", 6'h02, 1, 0);       endtask
  task automatic test_sw_wait(); run_instr("sw_wait", 6'h2b, 0, 3); endtask
  task automatic test_illegal(); run_instr("illegal", 6'h3f, 0, 0); endtask
  task automatic test_addi();    run_instr("addi", 6'h08, 0, 0);    endtask

  task automatic test_reset_mid();
    int k;
    build_path(6'h23, 0, 2);
    k = 0;
    while (exp_st_q[k] != 3) k++;
    run_path("rst_mid", 6'h23, k);
    op = 6'h23; mem_ready = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd3) begin errors++; $display("FAIL rst_mid_prestate: got %0d want 3", state); end
    checks++;
    if (dut_out() !== 17'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", dut_out()); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || reg_write !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after cyc%0d: got state %0d reg_write %b want 0 0", i, state, reg_write);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h3f, 6'h11};
    logic [5:0] o;
    for (int n = 0; n < 30; n++) begin
      o = ops[$urandom_range(0, 7)];
      if (o == 6'h11) o = 6'($urandom);
      run_instr("random", o, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; op = 6'h00; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jump();
    test_sw_wait();
    test_illegal();
    test_addi();
    test_reset_mid();
    test_back_to_back();
    test_lw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
